// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave view; the stream source and memory use the master view.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header count, little-endian words, XOR checksum.
// Holds the datapath in reset until a complete, checksum-verified image is in memory.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CAP_W    = 17;
  localparam int unsigned CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_LOAD, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t             state, state_nx;
  logic               accept_nx, done_nx, error_nx;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   word_cnt;
  logic [1:0]         byte_idx;
  logic [23:0]        asm_word;
  logic [7:0]         csum;
  logic               xfer, restart, last_word;
  logic [CNT_W-1:0]   hdr_count;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign restart   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign last_word = (word_cnt == count - CNT_W'(1));
  assign hdr_count = {bus.in_data, count[7:0]};

  // State register plus registered state decodes for the handshake and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      bus.in_ready <= 1'b0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nx;
      bus.in_ready <= accept_nx;
      core_reset   <= ~done_nx;
      done         <= done_nx;
      error        <= error_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    accept_nx = 1'b0;
    done_nx   = 1'b0;
    error_nx  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_HDR_LO;
      S_HDR_LO: if (xfer)  state_nx = S_HDR_HI;
      S_HDR_HI: begin
        if (xfer) begin
          if (CAP_W'(hdr_count) > CAP_W'(CAPACITY)) state_nx = S_ERROR;
          else if (hdr_count == '0)                  state_nx = S_CHK;
          else                                       state_nx = S_LOAD;
        end
      end
      S_LOAD:   if (xfer && (byte_idx == 2'd3) && last_word) state_nx = S_CHK;
      S_CHK:    if (xfer) state_nx = (bus.in_data == csum) ? S_DONE : S_ERROR;
      S_DONE:   if (start) state_nx = S_HDR_LO;
      S_ERROR:  if (start) state_nx = S_HDR_LO;
      default:  state_nx = S_IDLE;
    endcase
    accept_nx = (state_nx == S_HDR_LO) | (state_nx == S_HDR_HI) |
                (state_nx == S_LOAD)   | (state_nx == S_CHK);
    done_nx   = (state_nx == S_DONE);
    error_nx  = (state_nx == S_ERROR);
  end

  // Header capture, word assembly, checksum and the one-cycle memory write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      asm_word      <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      // Advance past a written word; the top address is held so it never wraps
      if (bus.mem_we && !(&bus.mem_addr)) bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(1);
      if (restart) begin
        word_cnt     <= '0;
        byte_idx     <= '0;
        csum         <= '0;
        bus.mem_addr <= '0;
      end
      if (xfer) begin
        case (state)
          S_HDR_LO: count[7:0]  <= bus.in_data;
          S_HDR_HI: count[15:8] <= bus.in_data;
          S_LOAD: begin
            csum     <= csum ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= bus.in_data;
              2'd1: asm_word[15:8]  <= bus.in_data;
              2'd2: asm_word[23:16] <= bus.in_data;
              default: begin
                bus.mem_wdata <= {bus.in_data, asm_word};
                bus.mem_we    <= 1'b1;
                word_cnt      <= word_cnt + CNT_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule
